// File: rtl/mem_stage_if.sv
// Data-memory request / read-return channel between the MEM stage and data memory.
//   req    : request valid (stage -> memory)
//   we     : 1 = store, 0 = load
//   addr   : byte address
//   wdata  : store data
//   ready  : request accepted this cycle (memory -> stage)
//   rvalid : load data valid
//   rdata  : load data
// Modports: master = MEM stage side, slave = memory side.
interface mem_stage_if;
    localparam int unsigned DATA_W = 32;

    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores from the EX/MEM register to data
// memory, owns the MEM/WB register (writeback + EX forwarding source) and
// stalls upstream while an access is outstanding.
// Ports:
//   clk, rst            : core clock, asynchronous active-high reset
//   EX_MEM_*            : EX/MEM register contents (held stable while MEM_stall)
//   dmem                : data-memory channel (mem_stage_if.master)
//   MEM_stall           : instruction in MEM cannot retire this cycle (combinational)
//   MEM_WB_result/rd/regwrite : registered writeback payload
//   MEM_error           : sticky access-timeout flag
// Optional feature: define MEM_TIMEOUT_EN to abandon an access after
// TIMEOUT_CYCLES stalled cycles; otherwise accesses wait indefinitely and
// MEM_error is tied low.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_MEM_valid,
    input  logic [31:0] EX_MEM_ALU_result,
    input  logic [31:0] EX_MEM_rs2_data,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic        EX_MEM_memtoreg,
    input  logic        EX_MEM_regwrite,
    mem_stage_if.master dmem,
    output logic        MEM_stall,
    output logic [31:0] MEM_WB_result,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic        MEM_error
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [0:0] {IDLE, WAIT_DATA} state_t;

    state_t             state, state_nxt;
    logic               memop_c;
    logic               wb_load_c;      // MEM/WB captures a new value this edge
    logic               mem_wait_c;     // memory op stalled this cycle (before timeout)
    logic               timeout_c;
    logic [DATA_W-1:0]  wb_result_nxt;
    logic               wb_regwrite_nxt;

`ifdef MEM_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timeout_cnt;
    assign timeout_c = mem_wait_c && (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));
`else
    localparam int unsigned unused_timeout_cfg = TIMEOUT_CYCLES + TIMEOUT_W;
    assign timeout_c = 1'b0;
`endif

    // Request channel, stall and MEM/WB next-value selection.
    always_comb begin
        memop_c         = EX_MEM_valid & (EX_MEM_memread | EX_MEM_memwrite);
        dmem.req        = 1'b0;
        dmem.we         = EX_MEM_memwrite;
        dmem.addr       = EX_MEM_ALU_result;
        dmem.wdata      = EX_MEM_rs2_data;
        MEM_stall       = 1'b0;
        mem_wait_c      = 1'b0;
        wb_load_c       = 1'b0;
        wb_result_nxt   = EX_MEM_ALU_result;
        wb_regwrite_nxt = EX_MEM_regwrite & EX_MEM_valid;
        state_nxt       = state;

        case (state)
            IDLE: begin
                dmem.req = memop_c;
                if (!memop_c) begin
                    wb_load_c = 1'b1;
                end else if (!dmem.ready) begin
                    mem_wait_c = 1'b1;
                end else if (EX_MEM_memwrite) begin
                    wb_load_c = 1'b1;
                end else begin
                    MEM_stall = 1'b1;
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (dmem.rvalid) begin
                    wb_load_c       = 1'b1;
                    wb_result_nxt   = EX_MEM_memtoreg ? dmem.rdata : EX_MEM_ALU_result;
                    wb_regwrite_nxt = EX_MEM_regwrite;
                    state_nxt       = IDLE;
                end else begin
                    mem_wait_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (mem_wait_c) begin
            MEM_stall = 1'b1;
        end

        // Abandon the access: retire with no writeback.
        if (timeout_c) begin
            MEM_stall       = 1'b0;
            wb_load_c       = 1'b1;
            wb_result_nxt   = '0;
            wb_regwrite_nxt = 1'b0;
            state_nxt       = IDLE;
        end

        if (rst) begin
            dmem.req  = 1'b0;
            MEM_stall = 1'b0;
        end
    end

    // State and MEM/WB register; MEM/WB holds while stalled to keep forwarding valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            MEM_WB_result   <= '0;
            MEM_WB_rd       <= '0;
            MEM_WB_regwrite <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wb_load_c) begin
                MEM_WB_result   <= wb_result_nxt;
                MEM_WB_rd       <= REG_W'(EX_MEM_rd);
                MEM_WB_regwrite <= wb_regwrite_nxt;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Stalled-cycle counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt <= '0;
            MEM_error   <= 1'b0;
        end else begin
            if (wb_load_c) begin
                timeout_cnt <= '0;
            end else if (mem_wait_c) begin
                timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
            end
            if (timeout_c) begin
                MEM_error <= 1'b1;
            end
        end
    end
`else
    assign MEM_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        EX_MEM_valid;
    logic [31:0] EX_MEM_ALU_result;
    logic [31:0] EX_MEM_rs2_data;
    logic [4:0]  EX_MEM_rd;
    logic        EX_MEM_memread;
    logic        EX_MEM_memwrite;
    logic        EX_MEM_memtoreg;
    logic        EX_MEM_regwrite;
    logic        MEM_stall;
    logic [31:0] MEM_WB_result;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_regwrite;
    logic        MEM_error;

    int tests  = 0;
    int failed = 0;

    mem_stage_if dmem_bus ();

    mem_stage #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .EX_MEM_valid      (EX_MEM_valid),
        .EX_MEM_ALU_result (EX_MEM_ALU_result),
        .EX_MEM_rs2_data   (EX_MEM_rs2_data),
        .EX_MEM_rd         (EX_MEM_rd),
        .EX_MEM_memread    (EX_MEM_memread),
        .EX_MEM_memwrite   (EX_MEM_memwrite),
        .EX_MEM_memtoreg   (EX_MEM_memtoreg),
        .EX_MEM_regwrite   (EX_MEM_regwrite),
        .dmem              (dmem_bus),
        .MEM_stall         (MEM_stall),
        .MEM_WB_result     (MEM_WB_result),
        .MEM_WB_rd         (MEM_WB_rd),
        .MEM_WB_regwrite   (MEM_WB_regwrite),
        .MEM_error         (MEM_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic mr, input logic mw,
                          input logic m2r, input logic rw);
        EX_MEM_valid      = v;
        EX_MEM_ALU_result = alu;
        EX_MEM_rs2_data   = wd;
        EX_MEM_rd         = rd;
        EX_MEM_memread    = mr;
        EX_MEM_memwrite   = mw;
        EX_MEM_memtoreg   = m2r;
        EX_MEM_regwrite   = rw;
    endtask

    task automatic chk_wb(input string tag, input logic [31:0] res, input logic [4:0] rd,
                          input logic rw);
        chk({tag, "_result"},   MEM_WB_result,        res);
        chk({tag, "_rd"},       32'(MEM_WB_rd),       32'(rd));
        chk({tag, "_regwrite"}, 32'(MEM_WB_regwrite), 32'(rw));
    endtask

    initial begin
        rst = 1'b1;
        set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_bus.ready  = 1'b0;
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata  = 32'h0;
        #2;
        chk("rst_req",   32'(dmem_bus.req), 32'd0);
        chk("rst_stall", 32'(MEM_stall),    32'd0);
        chk("rst_error", 32'(MEM_error),    32'd0);
        chk_wb("rst", 32'h0, 5'd0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // ALU op: one-cycle retire, no request
        set_ex(1'b1, 32'h0000_0010, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("add_req",   32'(dmem_bus.req), 32'd0);
        chk("add_stall", 32'(MEM_stall),    32'd0);
        step();
        chk_wb("add", 32'h10, 5'd5, 1'b1);

        // Store with ready low for 2 cycles
        set_ex(1'b1, 32'h100, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        dmem_bus.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("st_wait_req",   32'(dmem_bus.req), 32'd1);
            chk("st_wait_we",    32'(dmem_bus.we),  32'd1);
            chk("st_wait_addr",  dmem_bus.addr,     32'h100);
            chk("st_wait_wdata", dmem_bus.wdata,    32'hCAFE_F00D);
            chk("st_wait_stall", 32'(MEM_stall),    32'd1);
            step();
            chk_wb("st_hold", 32'h10, 5'd5, 1'b1);
        end
        dmem_bus.ready = 1'b1;
        #1;
        chk("st_acc_req",   32'(dmem_bus.req), 32'd1);
        chk("st_acc_addr",  dmem_bus.addr,     32'h100);
        chk("st_acc_stall", 32'(MEM_stall),    32'd0);
        step();
        chk_wb("st_ret", 32'h100, 5'd0, 1'b0);

        // Load, immediate accept, data three cycles later
        set_ex(1'b1, 32'h200, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        dmem_bus.ready = 1'b1;
        #1;
        chk("ld_acc_req",   32'(dmem_bus.req), 32'd1);
        chk("ld_acc_we",    32'(dmem_bus.we),  32'd0);
        chk("ld_acc_addr",  dmem_bus.addr,     32'h200);
        chk("ld_acc_stall", 32'(MEM_stall),    32'd1);
        step();
        dmem_bus.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ld_wait_req",   32'(dmem_bus.req), 32'd0);
            chk("ld_wait_stall", 32'(MEM_stall),    32'd1);
            chk_wb("ld_hold", 32'h100, 5'd0, 1'b0);
            step();
        end
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'h1234_5678;
        #1;
        chk("ld_rv_stall", 32'(MEM_stall),    32'd0);
        chk("ld_rv_req",   32'(dmem_bus.req), 32'd0);
        step();
        dmem_bus.rvalid = 1'b0;
        chk_wb("ld_ret", 32'h1234_5678, 5'd7, 1'b1);

        // Back-to-back loads
        set_ex(1'b1, 32'h300, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        dmem_bus.ready = 1'b1;
        #1;
        chk("ld1_req", 32'(dmem_bus.req), 32'd1);
        step();
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'hAAAA_0001;
        #1;
        chk("ld1_rv_req",   32'(dmem_bus.req), 32'd0);
        chk("ld1_rv_stall", 32'(MEM_stall),    32'd0);
        step();
        dmem_bus.rvalid = 1'b0;
        chk_wb("ld1_ret", 32'hAAAA_0001, 5'd8, 1'b1);
        set_ex(1'b1, 32'h304, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("ld2_req",   32'(dmem_bus.req), 32'd1);
        chk("ld2_addr",  dmem_bus.addr,     32'h304);
        chk("ld2_stall", 32'(MEM_stall),    32'd1);
        step();
        dmem_bus.ready  = 1'b0;
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'hBBBB_0002;
        #1;
        chk("ld2_wait_req", 32'(dmem_bus.req), 32'd0);
        chk_wb("ld2_hold", 32'hAAAA_0001, 5'd8, 1'b1);
        step();
        dmem_bus.rvalid = 1'b0;
        chk_wb("ld2_ret", 32'hBBBB_0002, 5'd9, 1'b1);

        // Load with memtoreg=0 writes back the ALU result
        set_ex(1'b1, 32'h0000_0ABC, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        dmem_bus.ready = 1'b1;
        step();
        dmem_bus.ready  = 1'b0;
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'hDEAD_BEEF;
        step();
        dmem_bus.rvalid = 1'b0;
        chk_wb("ld_alu", 32'h0000_0ABC, 5'd3, 1'b1);

        // Bubble carrying memread: no request, no write
        set_ex(1'b0, 32'h55, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("bub_req",   32'(dmem_bus.req), 32'd0);
        chk("bub_stall", 32'(MEM_stall),    32'd0);
        step();
        chk_wb("bub", 32'h55, 5'd4, 1'b0);

        // Reset while waiting for load data; late rvalid ignored
        set_ex(1'b1, 32'h400, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
        dmem_bus.ready = 1'b1;
        step();
        dmem_bus.ready = 1'b0;
        #1;
        chk("rw_wait_stall", 32'(MEM_stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_req",   32'(dmem_bus.req), 32'd0);
        chk("rw_stall", 32'(MEM_stall),    32'd0);
        chk_wb("rw", 32'h0, 5'd0, 1'b0);
        step();
        rst = 1'b0;
        set_ex(1'b0, 32'h44, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'hDEAD_0000;
        #1;
        chk("late_stall", 32'(MEM_stall), 32'd0);
        step();
        dmem_bus.rvalid = 1'b0;
        chk_wb("late", 32'h44, 5'd2, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // Ready never asserted: 4 stalled cycles, then forced retire
        set_ex(1'b1, 32'h500, 32'h1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        dmem_bus.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_stall", 32'(MEM_stall), 32'd1);
            chk("to_err0",  32'(MEM_error), 32'd0);
            step();
        end
        #1;
        chk("to_fire_stall", 32'(MEM_stall), 32'd0);
        step();
        set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_err1", 32'(MEM_error), 32'd1);
        chk("to_wb_regwrite", 32'(MEM_WB_regwrite), 32'd0);
        chk("to_wb_result",   MEM_WB_result,        32'd0);
        step();
        step();
        chk("to_err_sticky", 32'(MEM_error), 32'd1);
`else
        // Without the timeout, an unaccepted access keeps stalling
        set_ex(1'b1, 32'h500, 32'h1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        dmem_bus.ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        #1;
        chk("nto_stall", 32'(MEM_stall),    32'd1);
        chk("nto_req",   32'(dmem_bus.req), 32'd1);
        chk("nto_error", 32'(MEM_error),    32'd0);
        chk_wb("nto_hold", 32'h44, 5'd2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench did not complete");
    end
endmodule
